// File: rtl/sd101_frame_tx.sv
// ---------------------------------------------------------------------------
// sd101_frame_tx
//
// Sending end of the "101"-preamble bit-serial link.  A parallel payload word
// is taken over a valid/ready handshake. It is then sent on a single wire as:
//   preamble 1,0,1  ->  payload MSB-first  ->  optional even-parity bit.
// A fixed number of idle (GAP) cycles follows each frame before the next
// payload can be accepted.
//
// Parameters
//   WIDTH      payload bits per frame (>= 1)
//   PARITY_EN  1: append even-parity bit (XOR of payload), 0: no parity bit
//   GAP        forced idle cycles after each frame (0..15)
//
// Ports
//   clk         in   1      rising-edge clock
//   rst         in   1      asynchronous, active-low reset
//   load_valid  in   1      payload offered
//   load_data   in   WIDTH  payload word, sampled only on accept
//   load_ready  out  1      block can accept a payload this cycle (IDLE only)
//   dout        out  1      serial bit stream (0 whenever dout_en=0)
//   dout_en     out  1      high while dout carries a frame bit
//   frame_done  out  1      one-cycle pulse alongside the last frame bit
//
// Every output is a flop. The FSM therefore computes the value each output
// takes in the *next* cycle. The state register names the field whose bit
// is currently on dout, not the field that comes next.
// ---------------------------------------------------------------------------
module sd101_frame_tx #(
  parameter int WIDTH     = 8,
  parameter int PARITY_EN = 1,
  parameter int GAP       = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             dout,
  output logic             dout_en,
  output logic             frame_done
);

  // Bit counter holds WIDTH-1; keep at least one bit so WIDTH=1 still builds.
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  // Gap counter holds up to 15.
  localparam int GW = 4;

  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LOAD = (GAP > 0) ? GW'(GAP - 1) : '0;
  localparam logic          PAR_ON   = (PARITY_EN != 0);
  localparam logic          GAP_ON   = (GAP > 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_DATA,
    S_PAR,
    S_GAP
  } state_t;

  state_t           state, state_next;
  logic [1:0]       pre_cnt, pre_cnt_next;
  logic [BW-1:0]    bit_cnt, bit_cnt_next;
  logic [GW-1:0]    gap_cnt, gap_cnt_next;
  logic [WIDTH-1:0] shift, shift_next;
  logic             par, par_next;

  logic             dout_next;
  logic             dout_en_next;
  logic             frame_done_next;
  logic             load_ready_next;
  logic             end_frame;

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      pre_cnt    <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      shift      <= '0;
      par        <= 1'b0;
      dout       <= 1'b0;
      dout_en    <= 1'b0;
      frame_done <= 1'b0;
      load_ready <= 1'b1;
    end else begin
      state      <= state_next;
      pre_cnt    <= pre_cnt_next;
      bit_cnt    <= bit_cnt_next;
      gap_cnt    <= gap_cnt_next;
      shift      <= shift_next;
      par        <= par_next;
      dout       <= dout_next;
      dout_en    <= dout_en_next;
      frame_done <= frame_done_next;
      load_ready <= load_ready_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and next-output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next      = state;
    pre_cnt_next    = pre_cnt;
    bit_cnt_next    = bit_cnt;
    gap_cnt_next    = gap_cnt;
    shift_next      = shift;
    par_next        = par;
    dout_next       = 1'b0;
    dout_en_next    = 1'b0;
    frame_done_next = 1'b0;
    load_ready_next = 1'b0;
    end_frame       = 1'b0;

    case (state)
      S_IDLE: begin
        load_ready_next = 1'b1;
        if (load_valid && load_ready) begin
          // Capture the word and its parity now. The first preamble bit
          // appears on dout in the very next cycle.
          state_next      = S_PRE;
          pre_cnt_next    = 2'd0;
          shift_next      = load_data;
          par_next        = ^load_data;
          dout_next       = 1'b1;
          dout_en_next    = 1'b1;
          load_ready_next = 1'b0;
        end
      end

      S_PRE: begin
        dout_en_next = 1'b1;
        if (pre_cnt == 2'd2) begin
          // Third preamble bit is on the wire; next comes the payload MSB.
          state_next      = S_DATA;
          bit_cnt_next    = BIT_LAST;
          dout_next       = shift[WIDTH-1];
          shift_next      = shift << 1;
          // With a 1-bit payload and no parity, the MSB is also the last bit.
          frame_done_next = !PAR_ON && (BIT_LAST == '0);
        end else begin
          // pre_cnt 0 -> next bit 0, pre_cnt 1 -> next bit 1.
          pre_cnt_next = pre_cnt + 2'd1;
          dout_next    = pre_cnt[0];
        end
      end

      S_DATA: begin
        if (bit_cnt != '0) begin
          dout_en_next    = 1'b1;
          dout_next       = shift[WIDTH-1];
          shift_next      = shift << 1;
          bit_cnt_next    = bit_cnt - BW'(1);
          // The bit being loaded is the LSB when the counter reaches 0.
          frame_done_next = !PAR_ON && (bit_cnt == BW'(1));
        end else if (PAR_ON) begin
          state_next      = S_PAR;
          dout_en_next    = 1'b1;
          dout_next       = par;
          frame_done_next = 1'b1;
        end else begin
          end_frame = 1'b1;
        end
      end

      S_PAR: begin
        end_frame = 1'b1;
      end

      S_GAP: begin
        if (gap_cnt == '0) begin
          state_next      = S_IDLE;
          load_ready_next = 1'b1;
        end else begin
          gap_cnt_next = gap_cnt - GW'(1);
        end
      end

      default: begin
        state_next      = S_IDLE;
        load_ready_next = 1'b1;
      end
    endcase

    // The last frame bit is on the wire. Either hold the line idle for
    // GAP cycles, or re-open the handshake straight away.
    if (end_frame) begin
      if (GAP_ON) begin
        state_next   = S_GAP;
        gap_cnt_next = GAP_LOAD;
      end else begin
        state_next      = S_IDLE;
        load_ready_next = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sd101_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_sd101_frame_tx
//
// Directed bench for sd101_frame_tx.
//   dut_a: defaults (WIDTH=8, PARITY_EN=1, GAP=2)
//   dut_b: WIDTH=8, PARITY_EN=0, GAP=0
// Both instances share clk and rst. Outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_sd101_frame_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       lv_a, lv_b;
  logic [7:0] ld_a, ld_b;
  logic       ready_a, dout_a, en_a, done_a;
  logic       ready_b, dout_b, en_b, done_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sd101_frame_tx dut_a (
    .clk        (clk),
    .rst        (rst),
    .load_valid (lv_a),
    .load_data  (ld_a),
    .load_ready (ready_a),
    .dout       (dout_a),
    .dout_en    (en_a),
    .frame_done (done_a)
  );

  sd101_frame_tx #(.WIDTH(8), .PARITY_EN(0), .GAP(0)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .load_valid (lv_b),
    .load_data  (ld_b),
    .load_ready (ready_b),
    .dout       (dout_b),
    .dout_en    (en_b),
    .frame_done (done_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Send one word on dut_a and check the 12-bit frame, the 2 gap cycles and
  // the return to IDLE. With toggle set, load_valid/load_data are disturbed
  // throughout the frame and gap.
  task automatic run_a(input logic [7:0] d, input logic [11:0] exp_bits,
                       input bit toggle, input string tag);
    logic [11:0] bits;
    logic [11:0] ens;
    @(negedge clk);
    chk({tag, "_ready_before"}, 32'(ready_a), 32'd1);
    lv_a = 1'b1;
    ld_a = d;
    @(posedge clk);
    #1;
    lv_a = toggle;
    ld_a = toggle ? 8'hFF : 8'h00;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bits[11-i] = dout_a;
      ens[11-i]  = en_a;
      chk({tag, "_done_bit"}, 32'(done_a), 32'(i == 11));
      chk({tag, "_ready_busy"}, 32'(ready_a), 32'd0);
      if (toggle) begin
        lv_a = ~lv_a;
        ld_a = 8'hFF;
      end
    end
    chk({tag, "_stream"}, 32'(bits), 32'(exp_bits));
    chk({tag, "_dout_en"}, 32'(ens), 32'hFFF);
    for (int g = 0; g < 2; g++) begin
      @(negedge clk);
      chk({tag, "_gap"}, {29'd0, dout_a, en_a, ready_a}, 32'd0);
      chk({tag, "_gap_done"}, 32'(done_a), 32'd0);
      if (toggle) lv_a = (g == 0);
    end
    @(negedge clk);
    chk({tag, "_ready_after"}, 32'(ready_a), 32'd1);
    chk({tag, "_idle_en"}, 32'(en_a), 32'd0);
  endtask

  initial begin
    logic [26:0] s3, e3;
    logic [10:0] s6;

    // 1. Reset with random inputs.
    rst  = 1'b0;
    lv_a = 1'b0; ld_a = 8'h00;
    lv_b = 1'b0; ld_b = 8'h00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t1_rst_a", {28'd0, dout_a, en_a, done_a, ready_a}, 32'h1);
      chk("t1_rst_b", {28'd0, dout_b, en_b, done_b, ready_b}, 32'h1);
      lv_a = 1'($urandom); ld_a = 8'($urandom);
      lv_b = 1'($urandom); ld_b = 8'($urandom);
    end
    lv_a = 1'b0; lv_b = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // 2. Defaults, 8'hA5.
    run_a(8'hA5, 12'b101_10100101_0, 1'b0, "t2");

    // 3. Back-to-back 8'h00 then 8'hFF with load_valid held high.
    @(negedge clk);
    lv_a = 1'b1;
    ld_a = 8'h00;
    @(posedge clk);
    #1;
    ld_a = 8'hFF;
    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      s3[26-i] = dout_a;
      e3[26-i] = en_a;
      if (i == 14) chk("t3_ready_idle", 32'(ready_a), 32'd1);
      if (i == 15) lv_a = 1'b0;
    end
    chk("t3_stream", 32'(s3), 32'(27'b101_00000000_0_000_101_11111111_0));
    chk("t3_dout_en", 32'(e3), 32'(27'b111111111111_000_111111111111));
    for (int g = 0; g < 3; g++) @(negedge clk);
    chk("t3_ready_after", 32'(ready_a), 32'd1);

    // 4. 8'h3C with load_valid/load_data disturbed during the frame.
    run_a(8'h3C, 12'b101_00111100_0, 1'b1, "t4");

    // 5. Reset at the 4th data bit, then a clean 8'h81 frame.
    @(negedge clk);
    lv_a = 1'b1;
    ld_a = 8'hF0;
    @(posedge clk);
    #1;
    lv_a = 1'b0;
    for (int i = 0; i < 7; i++) @(negedge clk);
    chk("t5_mid_frame", {30'd0, dout_a, en_a}, 32'h3);
    #2;
    rst = 1'b0;
    #1;
    chk("t5_async_rst", {28'd0, dout_a, en_a, done_a, ready_a}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_in_rst", {28'd0, dout_a, en_a, done_a, ready_a}, 32'h1);
      lv_a = 1'($urandom); ld_a = 8'($urandom);
    end
    lv_a = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_a(8'h81, 12'b101_10000001_0, 1'b0, "t5");

    // 6. PARITY_EN=0, GAP=0 instance, 8'h01.
    @(negedge clk);
    chk("t6_ready_before", 32'(ready_b), 32'd1);
    lv_b = 1'b1;
    ld_b = 8'h01;
    @(posedge clk);
    #1;
    lv_b = 1'b0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      s6[10-i] = dout_b;
      chk("t6_en", 32'(en_b), 32'd1);
      chk("t6_done_bit", 32'(done_b), 32'(i == 10));
      chk("t6_ready_busy", 32'(ready_b), 32'd0);
    end
    chk("t6_stream", 32'(s6), 32'(11'b101_00000001));
    @(negedge clk);
    chk("t6_ready_next", 32'(ready_b), 32'd1);
    chk("t6_idle", {29'd0, dout_b, en_b, done_b}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
